// File: rtl/fm_modulator_if.sv
// fm_modulator_if: sample-stream bundle between a message source and the FM
// modulator.
//   en     : sample strobe; m, fc and kf are taken on every rising edge with en=1
//   m      : signed 16-bit message sample
//   fc     : unsigned carrier phase increment per sample
//   kf     : unsigned 8-bit deviation gain
//   I, Q   : signed 8-bit quadrature output samples (registered)
//   valid  : one-cycle strobe marking a new I/Q pair
// Handshake: there is no ready signal. The source may assert en on any cycle,
// and the consumer must take I/Q on every cycle in which valid=1.
// master = sample source / consumer side, slave = modulator side.
interface fm_modulator_if #(
   parameter int ACC_W = 24
);
   logic                    en;
   logic signed [15:0]      m;
   logic        [ACC_W-1:0] fc;
   logic        [7:0]       kf;
   logic signed [7:0]       I;
   logic signed [7:0]       Q;
   logic                    valid;

   modport master (output en, m, fc, kf, input I, Q, valid);
   modport slave  (input en, m, fc, kf, output I, Q, valid);
endinterface

// File: rtl/fm_modulator.sv
// fm_modulator: quadrature FM modulator for the transmit path.
// Each accepted message sample advances a phase accumulator by fc plus a
// scaled deviation (m*kf >>> KF_SHIFT). The top 10 phase bits address a
// quarter-wave sine table, and the result is 8-bit signed I/Q = 127*cos/sin.
// Ports:
//   clk  : clock, all logic on the rising edge
//   rst  : synchronous active-high reset
//   bus  : fm_modulator_if slave (en, m, fc, kf in; I, Q, valid out)
// Pipeline: stage 1 increment, stage 2 accumulate, stage 3 lookup. valid
// follows en by three edges and throughput is one sample per clock.
module fm_modulator #(
   parameter int ACC_W    = 24,
   parameter int KF_SHIFT = 8
) (
   input  logic           clk,
   input  logic           rst,
   fm_modulator_if.slave  bus
);

   // pi scaled by 2^30, used only while the table is built at elaboration.
   localparam longint PI_Q30 = 64'sd3373259426;

   // round(127*sin(2*pi*k/1024)) for k in 0..256, built from a fixed-point
   // Taylor series. The argument stays within [0, pi/2], so the partial
   // products fit in 64 bits. The rounding is always for a non-negative value,
   // so adding one half and flooring rounds half away from zero.
   function automatic logic [6:0] quarter_sin(input int k);
      longint x;
      longint term;
      longint sum;
      longint scaled;
      x    = (PI_Q30 * longint'(k)) / 512;
      term = x;
      sum  = x;
      for (int n = 1; n <= 12; n++) begin
         term = (term * x) >>> 30;
         term = (term * x) >>> 30;
         term = -(term / longint'((2 * n) * (2 * n + 1)));
         sum  = sum + term;
      end
      scaled = (sum * 127 + (64'sd1 <<< 29)) >>> 30;
      return scaled[6:0];
   endfunction

   logic [6:0] sin_tab [0:256];

   for (genvar k = 0; k <= 256; k++) begin : g_tab
      localparam logic [6:0] ENTRY = quarter_sin(k);
      assign sin_tab[k] = ENTRY;
   end

   // Stage 1: deviation and per-sample increment.
   logic signed [24:0]      prod;
   logic signed [24:0]      dev;
   logic signed [ACC_W-1:0] dev_ext;
   logic        [ACC_W-1:0] inc_r;
   logic                    v1;

   // kf is zero-extended, so the product is a signed 16x9 multiply.
   assign prod    = bus.m * $signed({1'b0, bus.kf});
   assign dev     = prod >>> KF_SHIFT;
   assign dev_ext = ACC_W'(dev);

   // Stage 2: phase accumulator, which wraps modulo 2^ACC_W.
   logic [ACC_W-1:0] phase;
   logic             v2;

   // Stage 3: quadrant folding onto the quarter-wave table.
   // quad 0: sin=+S[i],     cos=+S[256-i]
   // quad 1: sin=+S[256-i], cos=-S[i]
   // quad 2: sin=-S[i],     cos=-S[256-i]
   // quad 3: sin=-S[256-i], cos=+S[i]
   logic        [9:0] a;
   logic        [1:0] quad;
   logic        [8:0] idx_fwd;
   logic        [8:0] idx_rev;
   logic        [6:0] sin_mag;
   logic        [6:0] cos_mag;
   logic              sin_neg;
   logic              cos_neg;
   logic signed [7:0] i_next;
   logic signed [7:0] q_next;
   logic signed [7:0] i_r;
   logic signed [7:0] q_r;
   logic              v3;

   assign a       = phase[ACC_W-1 -: 10];
   assign quad    = a[9:8];
   assign idx_fwd = {1'b0, a[7:0]};
   assign idx_rev = 9'd256 - idx_fwd;
   assign sin_mag = quad[0] ? sin_tab[idx_rev] : sin_tab[idx_fwd];
   assign cos_mag = quad[0] ? sin_tab[idx_fwd] : sin_tab[idx_rev];
   assign sin_neg = quad[1];
   assign cos_neg = quad[1] ^ quad[0];
   assign i_next  = cos_neg ? -$signed({1'b0, cos_mag}) : $signed({1'b0, cos_mag});
   assign q_next  = sin_neg ? -$signed({1'b0, sin_mag}) : $signed({1'b0, sin_mag});

   // Each stage register loads only when its valid input is set, so the
   // phase advances once per accepted sample whatever the gaps in en.
   always_ff @(posedge clk) begin
      if (rst) begin
         inc_r <= '0;
         phase <= '0;
         i_r   <= '0;
         q_r   <= '0;
         v1    <= 1'b0;
         v2    <= 1'b0;
         v3    <= 1'b0;
      end else begin
         v1 <= bus.en;
         v2 <= v1;
         v3 <= v2;
         if (bus.en) begin
            inc_r <= bus.fc + $unsigned(dev_ext);
         end
         if (v1) begin
            phase <= phase + inc_r;
         end
         if (v2) begin
            i_r <= i_next;
            q_r <= q_next;
         end
      end
   end

   assign bus.I     = i_r;
   assign bus.Q     = q_r;
   assign bus.valid = v3;

endmodule

// File: tb/tb_fm_modulator.sv
// tb_fm_modulator: directed self-checking bench for fm_modulator.
// Inputs are driven 1 ns after each rising edge, and outputs are sampled at
// the same point. That point sits between edges, clear of the active edge.
module tb_fm_modulator;

   logic clk;
   logic rst;
   int   tests_run;
   int   tests_failed;

   fm_modulator_if #(.ACC_W(24)) bus ();

   fm_modulator #(
      .ACC_W    (24),
      .KF_SHIFT (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      bus.en = 1'b0;
      rst    = 1'b1;
      tick();
      tick();
      rst    = 1'b0;
   endtask

   // Send one sample on the next edge, then release en.
   task automatic send_sample(input logic [23:0] fc, input logic signed [15:0] m,
                              input logic [7:0] kf);
      bus.fc = fc;
      bus.m  = m;
      bus.kf = kf;
      bus.en = 1'b1;
      tick();
      bus.en = 1'b0;
   endtask

   task automatic test_reset();
      // en is held high during reset, and the sample must be dropped.
      rst    = 1'b1;
      bus.en = 1'b1;
      bus.fc = 24'h0;
      bus.m  = 16'sd0;
      bus.kf = 8'd0;
      tick();
      tick();
      tests_run++;
      if (bus.valid !== 1'b0 || bus.I !== 8'sd0 || bus.Q !== 8'sd0) begin
         tests_failed++;
         $display("FAIL reset_state: valid=%b I=%0d Q=%0d, want valid=0 I=0 Q=0",
                  bus.valid, bus.I, bus.Q);
      end
      rst    = 1'b0;
      bus.en = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         tests_run++;
         if (bus.valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_and_en_dropped: valid=%b at cycle %0d, want 0", bus.valid, c);
         end
      end
      send_sample(24'h0, 16'sd0, 8'd0);
      tick();
      tests_run++;
      if (bus.valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL first_latency_early: valid=%b after 2 edges, want 0", bus.valid);
      end
      tick();
      tests_run++;
      if (bus.valid !== 1'b1 || bus.I !== 8'sd127 || bus.Q !== 8'sd0) begin
         tests_failed++;
         $display("FAIL first_sample: valid=%b I=%0d Q=%0d, want valid=1 I=127 Q=0",
                  bus.valid, bus.I, bus.Q);
      end
      tick();
      tests_run++;
      if (bus.valid !== 1'b0 || bus.I !== 8'sd127 || bus.Q !== 8'sd0) begin
         tests_failed++;
         $display("FAIL output_hold: valid=%b I=%0d Q=%0d, want valid=0 I=127 Q=0",
                  bus.valid, bus.I, bus.Q);
      end
   endtask

   task automatic test_quarter_turn();
      logic signed [7:0] exp_i [4] = '{8'sd0, -8'sd127, 8'sd0, 8'sd127};
      logic signed [7:0] exp_q [4] = '{8'sd127, 8'sd0, -8'sd127, 8'sd0};
      logic [2:0] hist;
      int got;
      apply_reset();
      bus.fc = 24'h400000;
      bus.m  = 16'sd0;
      bus.kf = 8'd0;
      hist   = '0;
      got    = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         bus.en = (cyc < 8);
         tick();
         hist = {hist[1:0], bus.en};
         tests_run++;
         if (bus.valid !== hist[2]) begin
            tests_failed++;
            $display("FAIL quarter_valid: cycle %0d valid=%b, want %b", cyc, bus.valid, hist[2]);
         end
         if (bus.valid === 1'b1) begin
            tests_run++;
            if (bus.I !== exp_i[got % 4] || bus.Q !== exp_q[got % 4]) begin
               tests_failed++;
               $display("FAIL quarter_iq: sample %0d got (%0d,%0d), want (%0d,%0d)",
                        got, bus.I, bus.Q, exp_i[got % 4], exp_q[got % 4]);
            end
            got++;
         end
      end
      bus.en = 1'b0;
      tests_run++;
      if (got != 8) begin
         tests_failed++;
         $display("FAIL quarter_count: got %0d valid strobes, want 8", got);
      end
   endtask

   task automatic test_wrap();
      logic signed [7:0] exp_i [4] = '{8'sd0, -8'sd127, 8'sd0, 8'sd127};
      logic signed [7:0] exp_q [4] = '{-8'sd127, 8'sd0, 8'sd127, 8'sd0};
      logic [2:0] hist;
      int got;
      apply_reset();
      bus.fc = 24'hC00000;
      bus.m  = 16'sd0;
      bus.kf = 8'd0;
      hist   = '0;
      got    = 0;
      for (int cyc = 0; cyc < 10; cyc++) begin
         bus.en = (cyc < 8);
         tick();
         hist = {hist[1:0], bus.en};
         tests_run++;
         if (bus.valid !== hist[2]) begin
            tests_failed++;
            $display("FAIL wrap_valid: cycle %0d valid=%b, want %b", cyc, bus.valid, hist[2]);
         end
         if (bus.valid === 1'b1) begin
            tests_run++;
            if (bus.I !== exp_i[got % 4] || bus.Q !== exp_q[got % 4]) begin
               tests_failed++;
               $display("FAIL wrap_iq: sample %0d got (%0d,%0d), want (%0d,%0d)",
                        got, bus.I, bus.Q, exp_i[got % 4], exp_q[got % 4]);
            end
            got++;
         end
      end
      bus.en = 1'b0;
      tests_run++;
      if (got != 8) begin
         tests_failed++;
         $display("FAIL wrap_count: got %0d valid strobes, want 8", got);
      end
   endtask

   task automatic test_gapped();
      logic signed [7:0] exp_i [4] = '{8'sd0, -8'sd127, 8'sd0, 8'sd127};
      logic signed [7:0] exp_q [4] = '{8'sd127, 8'sd0, -8'sd127, 8'sd0};
      logic [2:0] hist;
      int got;
      apply_reset();
      bus.fc = 24'h400000;
      bus.m  = 16'sd0;
      bus.kf = 8'd0;
      hist   = '0;
      got    = 0;
      for (int cyc = 0; cyc < 28; cyc++) begin
         bus.en = (cyc % 3 == 0) && (cyc < 24);
         tick();
         hist = {hist[1:0], bus.en};
         tests_run++;
         if (bus.valid !== hist[2]) begin
            tests_failed++;
            $display("FAIL gapped_valid: cycle %0d valid=%b, want %b", cyc, bus.valid, hist[2]);
         end
         if (bus.valid === 1'b1) begin
            tests_run++;
            if (bus.I !== exp_i[got % 4] || bus.Q !== exp_q[got % 4]) begin
               tests_failed++;
               $display("FAIL gapped_iq: sample %0d got (%0d,%0d), want (%0d,%0d)",
                        got, bus.I, bus.Q, exp_i[got % 4], exp_q[got % 4]);
            end
            got++;
         end
      end
      bus.en = 1'b0;
      tests_run++;
      if (got != 8) begin
         tests_failed++;
         $display("FAIL gapped_count: got %0d valid strobes, want 8", got);
      end
   endtask

   task automatic test_deviation();
      // Negative full-scale deviation: inc=0xFFC000, a=1023.
      apply_reset();
      send_sample(24'h0, -16'sd32768, 8'd128);
      tick();
      tick();
      tests_run++;
      if (bus.valid !== 1'b1 || bus.I !== 8'sd127 || bus.Q !== -8'sd1) begin
         tests_failed++;
         $display("FAIL dev_negative: valid=%b I=%0d Q=%0d, want valid=1 I=127 Q=-1",
                  bus.valid, bus.I, bus.Q);
      end
      // Positive deviation, back to back. 32767*255>>>8 = 0x7F7E, which gives
      // a=1 and then a=3.
      apply_reset();
      bus.fc = 24'h0;
      bus.m  = 16'sd32767;
      bus.kf = 8'd255;
      bus.en = 1'b1;
      tick();
      tick();
      bus.en = 1'b0;
      tick();
      tests_run++;
      if (bus.valid !== 1'b1 || bus.I !== 8'sd127 || bus.Q !== 8'sd1) begin
         tests_failed++;
         $display("FAIL dev_positive_1: valid=%b I=%0d Q=%0d, want valid=1 I=127 Q=1",
                  bus.valid, bus.I, bus.Q);
      end
      tick();
      tests_run++;
      if (bus.valid !== 1'b1 || bus.I !== 8'sd127 || bus.Q !== 8'sd2) begin
         tests_failed++;
         $display("FAIL dev_positive_2: valid=%b I=%0d Q=%0d, want valid=1 I=127 Q=2",
                  bus.valid, bus.I, bus.Q);
      end
      // Carrier plus deviation: inc=0x3FC000, a=255.
      apply_reset();
      send_sample(24'h400000, -16'sd32768, 8'd128);
      tick();
      tick();
      tests_run++;
      if (bus.valid !== 1'b1 || bus.I !== 8'sd1 || bus.Q !== 8'sd127) begin
         tests_failed++;
         $display("FAIL dev_with_carrier: valid=%b I=%0d Q=%0d, want valid=1 I=1 Q=127",
                  bus.valid, bus.I, bus.Q);
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      bus.fc = 24'h400000;
      bus.m  = 16'sd0;
      bus.kf = 8'd0;
      bus.en = 1'b1;
      tick();
      tick();
      bus.en = 1'b0;
      rst    = 1'b1;
      tick();
      rst    = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tests_run++;
         if (bus.valid !== 1'b0 || bus.I !== 8'sd0 || bus.Q !== 8'sd0) begin
            tests_failed++;
            $display("FAIL mid_reset_flush: cycle %0d valid=%b I=%0d Q=%0d, want 0 0 0",
                     c, bus.valid, bus.I, bus.Q);
         end
         tick();
      end
      send_sample(24'h400000, 16'sd0, 8'd0);
      tick();
      tick();
      tests_run++;
      if (bus.valid !== 1'b1 || bus.I !== 8'sd0 || bus.Q !== 8'sd127) begin
         tests_failed++;
         $display("FAIL mid_reset_restart: valid=%b I=%0d Q=%0d, want valid=1 I=0 Q=127",
                  bus.valid, bus.I, bus.Q);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst          = 1'b1;
      bus.en       = 1'b0;
      bus.m        = 16'sd0;
      bus.fc       = 24'h0;
      bus.kf       = 8'd0;
      test_reset();
      test_quarter_turn();
      test_deviation();
      test_wrap();
      test_gapped();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/fm_modulator.md
# fm_modulator

Quadrature FM modulator for the transmit path. Each accepted 16-bit signed message sample `m` advances a phase accumulator by a carrier frequency word plus a scaled deviation term. The accumulated phase drives a cosine/sine lookup that produces 8-bit signed I/Q samples. Its output format matches the 8-bit I/Q inputs of the receive-path quadrature discriminator, so the two blocks can be connected back to back for loopback.

## Interface
- `ACC_W`, 24: phase accumulator width; one full turn is 2^ACC_W.
- `KF_SHIFT`, 8: arithmetic right shift applied to the product `m*kf`.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  sample strobe; `m` is accepted on any rising edge with `en`=1.
- `m`  in  16  signed message sample.
- `fc`  in  ACC_W  unsigned carrier phase increment per sample; sampled with `m`.
- `kf`  in  8  unsigned deviation gain; sampled with `m`.
- `I`  out  8  signed in-phase sample, registered.
- `Q`  out  8  signed quadrature sample, registered.
- `valid`  out  1  one-cycle strobe; `I`/`Q` hold a new sample.

## Operation
- The datapath is a 3-stage pipeline with valid bits `v1`, `v2` and `v3`. `valid` = `v3`.
- **Stage 1** (when `en`=1):
  - `prod` = `m` × {0,`kf`}, computed as a 25-bit signed product.
  - `dev` = `prod` >>> `KF_SHIFT`, arithmetic shift.
  - `inc_r` <= (`fc` + sign-extended `dev`) mod 2^ACC_W.
  - `v1` <= `en`.
- **Stage 2** (when `v1`=1):
  - `phase` <= (`phase` + `inc_r`) mod 2^ACC_W. Wrap-around is silent.
  - `v2` <= `v1`.
- **Stage 3** (when `v2`=1):
  - `a` = `phase`[ACC_W-1 -: 10], i.e. 1024 points per turn.
  - `I` <= round(127·cos(2πa/1024)).
  - `Q` <= round(127·sin(2πa/1024)).
  - Rounding is half away from zero, and results stay within ±127.
  - The implementation may use a full table or a quarter-wave table with quadrant folding. Outputs must be bit-exact to the formula.
  - `v3` <= `v2`.
- Stage registers whose valid input is 0 hold their contents. `phase` advances exactly once per accepted sample, independent of gaps in `en`.
- `I` and `Q` hold their last value between `valid` strobes.
- The phase used for sample n is the sum of all increments up to and including sample n. It is never the pre-increment value.
- **Reset:**
  - Clears `inc_r`, `phase`, `v1`, `v2`, `v3`, `I` and `Q` to 0.
  - `valid`=0.
- **Reset mid-operation:** in-flight samples are discarded with no `valid` pulse. `phase` restarts from 0.
- **`rst` and `en` in the same cycle:** `rst` wins and the sample is dropped.
- **Sign convention:** positive `m·kf` gives counter-clockwise rotation, i.e. increasing phase. The receive discriminator computes I·Q_last − Q·I_last, so its output has the opposite sign to the deviation.

## Timing
- `en` at edge n → `inc_r` at n, `phase` at n+1, `I`/`Q`/`valid` at n+2. `valid` is therefore high during cycle n+3: three cycles of latency.
- Throughput is one sample per clock. Back-to-back `en` produces back-to-back `valid`.
- There is no backpressure. The downstream consumer must accept every `valid` strobe.
- The critical path is the stage-1 16×9 multiply plus add. Do not merge stages.

## Test plan
- **Reset:** after `rst`, `I`=0, `Q`=0, `valid`=0.
  - First sample with `fc`=0, `m`=0, `kf`=0 gives `valid` 3 cycles later with `I`=127, `Q`=0.
- **Quarter-turn carrier:** `fc`=0x400000, `m`=0, `en` held high.
  - Outputs (`I`,`Q`) = (0,127), (−127,0), (0,−127), (127,0), repeating.
- **Deviation:** `fc`=0, `kf`=128, single `m`=−32768.
  - `inc` = 0xFFC000, `a`=1023.
  - Output is `I`=127, `Q`=−1.
- **Wrap-around:** `fc`=0xC00000, `en` held high.
  - Phase sequence 0xC00000, 0x800000, 0x400000, 0x000000.
  - Outputs (0,−127), (−127,0), (0,127), (127,0).
- **Gapped strobe:** `en` high every 3rd cycle, `fc`=0x400000.
  - `valid` pulses exactly 3 cycles after each `en`.
  - The I/Q sequence is identical to the quarter-turn carrier case.
- **Reset mid-stream:** `rst` for one cycle while 2 samples are in flight.
  - No `valid` for those samples.
  - The next sample, with `fc`=0x400000, yields (0,127).
